// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - cpu6502 bus bundle between core (master) and memory responder (slave)
//
// Signals:
//   address  16  CPU address
//   write    1   CPU write strobe
//   wdata    8   CPU write data (core data_o)
//   rdata    8   read data back to the core (core data_i)
//   ready    1   0 stalls the CPU
interface mem_responder_if;
    logic [15:0] address;
    logic        write;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ready;

    modport master (
        output address,
        output write,
        output wdata,
        input  rdata,
        input  ready
    );

    modport slave (
        input  address,
        input  write,
        input  wdata,
        output rdata,
        output ready
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - cpu6502 memory responder: RAM, timer I/O page, vector/fill ROM with wait states
//
// Ports:
//   clk      in   single clock, all state on its rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of mem_responder_if (address/write/wdata in, rdata/ready out, both registered)
//   irq      out  level interrupt request (TF & IE), registered
//   nmi_btn  in   asynchronous external NMI source
//   nmi      out  synchronized NMI level
module mem_responder #(
    parameter int          RAM_AW    = 11,
    parameter logic [7:0]  IO_PAGE   = 8'hD0,
    parameter logic [15:0] RESET_VEC = 16'hF000,
    parameter logic [15:0] IRQ_VEC   = 16'hF100,
    parameter logic [15:0] NMI_VEC   = 16'hF200,
    parameter logic [7:0]  FILL_BYTE = 8'hEA,
    parameter int          ROM_WAIT  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    mem_responder_if.slave  bus,
    output logic            irq,
    input  logic            nmi_btn,
    output logic            nmi
);

    localparam int RAM_DEPTH = 1 << RAM_AW;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    // Wait-state FSM and bus output registers
    state_t      state_q, state_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic [15:0] rom_addr_q, rom_addr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        ready_q, ready_d;

    // Timer / status registers
    logic [15:0] count_q, count_d;
    logic [15:0] reload_q, reload_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        auto_q, auto_d;
    logic        tf_q, tf_d;
    logic        nf_q, nf_d;
    logic        irq_q, irq_d;

    // [0] first sync stage, [1] synchronized level, [2] delayed copy for edge detect
    logic [2:0]  sync_q, sync_d;

    logic [7:0]  ram [RAM_DEPTH];

    // Address decode; RAM wins, then the I/O page, everything else is ROM
    logic idle;
    logic sel_ram;
    logic sel_io;
    logic io_hit;
    logic wr_ram;
    logic wr_io;
    logic wr_tlo;
    logic wr_thi;
    logic wr_ctrl;
    logic wr_stat;
    logic [7:0] ram_rd;
    logic [7:0] io_rd;
    logic tf_set;
    logic nf_set;

    assign idle    = (state_q == S_IDLE);
    assign sel_ram = ({1'b0, bus.address} < 17'(RAM_DEPTH));
    assign sel_io  = !sel_ram && (bus.address[15:8] == IO_PAGE);
    // Only the first four offsets of the page hold registers
    assign io_hit  = (bus.address[7:2] == 6'd0);

    // Address is held by the CPU during WAIT, so bus activity is only honoured in IDLE
    assign wr_ram  = idle && bus.write && sel_ram;
    assign wr_io   = idle && bus.write && sel_io && io_hit;
    assign wr_tlo  = wr_io && (bus.address[1:0] == 2'd0);
    assign wr_thi  = wr_io && (bus.address[1:0] == 2'd1);
    assign wr_ctrl = wr_io && (bus.address[1:0] == 2'd2);
    assign wr_stat = wr_io && (bus.address[1:0] == 2'd3);

    assign ram_rd  = ram[bus.address[RAM_AW-1:0]];

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        logic [7:0] b;
        case (a)
            16'hFFFA: b = NMI_VEC[7:0];
            16'hFFFB: b = NMI_VEC[15:8];
            16'hFFFC: b = RESET_VEC[7:0];
            16'hFFFD: b = RESET_VEC[15:8];
            16'hFFFE: b = IRQ_VEC[7:0];
            16'hFFFF: b = IRQ_VEC[15:8];
            default:  b = FILL_BYTE;
        endcase
        return b;
    endfunction

    always_comb begin
        io_rd = 8'h00;
        if (io_hit) begin
            case (bus.address[1:0])
                2'd0: io_rd = count_q[7:0];
                2'd1: io_rd = count_q[15:8];
                2'd2: io_rd = {5'd0, auto_q, ie_q, en_q};
                2'd3: io_rd = {6'd0, nf_q, tf_q};
                default: io_rd = 8'h00;
            endcase
        end
    end

    // RAM contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram[bus.address[RAM_AW-1:0]] <= bus.wdata;
        end
    end

    // Wait-state FSM: next state and registered bus outputs
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        rom_addr_d = rom_addr_q;
        rdata_d    = rdata_q;
        ready_d    = ready_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (!bus.write) begin
                    if (sel_ram) begin
                        rdata_d = ram_rd;
                    end else if (sel_io) begin
                        rdata_d = io_rd;
                    end else if (ROM_WAIT == 0) begin
                        rdata_d = rom_byte(bus.address);
                    end else if (ready_q) begin
                        // Latch the address so the completion does not depend on the bus
                        state_d    = S_WAIT;
                        wcnt_d     = 3'(ROM_WAIT);
                        rom_addr_d = bus.address;
                        ready_d    = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                ready_d = 1'b0;
                if (wcnt_q == 3'd1) begin
                    state_d = S_IDLE;
                    wcnt_d  = 3'd0;
                    ready_d = 1'b1;
                    rdata_d = rom_byte(rom_addr_q);
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // Timer, status flags and NMI synchronizer
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        en_d     = en_q;
        ie_d     = ie_q;
        auto_d   = auto_q;
        tf_set   = 1'b0;
        sync_d   = {sync_q[1:0], nmi_btn};
        nf_set   = sync_q[1] && !sync_q[2];
        irq_d    = tf_q && ie_q;

        if (en_q) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else begin
                tf_set = 1'b1;
                if (auto_q) begin
                    count_d = reload_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        if (wr_tlo) begin
            reload_d[7:0] = bus.wdata;
        end
        if (wr_thi) begin
            reload_d[15:8] = bus.wdata;
        end

        // A CTRL write overrides the expiry's EN clear; only a 0->1 EN edge reloads
        if (wr_ctrl) begin
            en_d   = bus.wdata[0];
            ie_d   = bus.wdata[1];
            auto_d = bus.wdata[2];
            if (!en_q && bus.wdata[0]) begin
                count_d = reload_q;
            end
        end

        // Set beats a same-cycle write-one-to-clear
        tf_d = (tf_q && !(wr_stat && bus.wdata[0])) || tf_set;
        nf_d = (nf_q && !(wr_stat && bus.wdata[1])) || nf_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wcnt_q     <= 3'd0;
            rom_addr_q <= 16'd0;
            rdata_q    <= 8'h00;
            ready_q    <= 1'b1;
            count_q    <= 16'd0;
            reload_q   <= 16'd0;
            en_q       <= 1'b0;
            ie_q       <= 1'b0;
            auto_q     <= 1'b0;
            tf_q       <= 1'b0;
            nf_q       <= 1'b0;
            irq_q      <= 1'b0;
            sync_q     <= 3'd0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            rom_addr_q <= rom_addr_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            en_q       <= en_d;
            ie_q       <= ie_d;
            auto_q     <= auto_d;
            tf_q       <= tf_d;
            nf_q       <= nf_d;
            irq_q      <= irq_d;
            sync_q     <= sync_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign irq       = irq_q;
    assign nmi       = sync_q[1];

endmodule
